// File: rtl/barcode_to_num_reader.sv
// rtl/barcode_to_num_reader.sv - serial 11-segment barcode digit reader with guard and codebook check
// Optional BARCODE_ERR_COUNT_EN adds a saturating err_count output.
module barcode_to_num_reader #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_valid,
  input  logic       seg_in,
  output logic [0:3] number,
  output logic       num_valid,
  output logic       code_err,
  output logic       busy
`ifdef BARCODE_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

  state_t      state, state_nxt;
  logic [10:0] shreg;
  logic [3:0]  seg_cnt;
  logic [7:0]  tmo_cnt;
  logic        start, shift_in, last_seg, tmo_hit;
  logic        code_hit, load_num, raise_err;
  logic [3:0]  code_num;

  // CHECK behaves like IDLE for an incoming strobe so back-to-back symbols are not lost
  assign start    = seg_valid && seg_in && (state == IDLE || state == CHECK);
  assign shift_in = (state == COLLECT) && seg_valid;
  assign last_seg = shift_in && (seg_cnt == 4'd10);
  assign tmo_hit  = (state == COLLECT) && !seg_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: begin
        if (last_seg)     state_nxt = CHECK;
        else if (tmo_hit) state_nxt = IDLE;
      end
      CHECK:   state_nxt = start ? COLLECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    load_num  = (state == CHECK) && !shreg[0] && code_hit;
    raise_err = ((state == CHECK) && !(!shreg[0] && code_hit)) || tmo_hit;
  end

  // segment 1 ends up in shreg[10], matching the left-to-right codebook notation
  always_comb begin
    code_hit = 1'b1;
    code_num = 4'd0;
    case (shreg)
      11'b11011001100: code_num = 4'd0;
      11'b11001101100: code_num = 4'd1;
      11'b11001100110: code_num = 4'd2;
      11'b10010011000: code_num = 4'd3;
      11'b10010001100: code_num = 4'd4;
      11'b10001001100: code_num = 4'd5;
      11'b10011001000: code_num = 4'd6;
      11'b10011000100: code_num = 4'd7;
      11'b10001100100: code_num = 4'd8;
      11'b11001001100: code_num = 4'd9;
      11'b11001000100: code_num = 4'd10;
      11'b11000100100: code_num = 4'd11;
      11'b10110011000: code_num = 4'd12;
      11'b10011011100: code_num = 4'd13;
      11'b10011001110: code_num = 4'd14;
      11'b10111001100: code_num = 4'd15;
      default:         code_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      number    <= 4'd0;
      num_valid <= 1'b0;
      code_err  <= 1'b0;
      shreg     <= 11'd0;
      seg_cnt   <= 4'd0;
      tmo_cnt   <= 8'd0;
    end else begin
      num_valid <= load_num;
      code_err  <= raise_err;
      if (load_num) number <= code_num;
      if (start) begin
        shreg   <= 11'd1;
        seg_cnt <= 4'd1;
        tmo_cnt <= 8'd0;
      end else if (shift_in) begin
        shreg   <= {shreg[9:0], seg_in};
        seg_cnt <= seg_cnt + 4'd1;
        tmo_cnt <= 8'd0;
      end else if (state == COLLECT) begin
        tmo_cnt <= tmo_hit ? 8'd0 : tmo_cnt + 8'd1;
      end
    end
  end

`ifdef BARCODE_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                             err_count <= 8'd0;
    else if (raise_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_barcode_to_num_reader.sv
// tb/tb_barcode_to_num_reader.sv - scoreboard and table-driven bench for barcode_to_num_reader
module tb_barcode_to_num_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seg_valid = 1'b0;
  logic       seg_in = 1'b0;
  logic [0:3] number;
  logic       num_valid, code_err, busy;
`ifdef BARCODE_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [10:0] code;
    bit          err;
    logic [3:0]  num;
    int          gap;
  } vec_t;

  typedef struct {
    bit         err;
    logic [3:0] num;
  } exp_t;

  vec_t       tbl[20];
  exp_t       sb[$];
  logic [3:0] last_num = 4'd0;

  barcode_to_num_reader #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_valid (seg_valid),
    .seg_in    (seg_in),
    .number    (number),
    .num_valid (num_valid),
    .code_err  (code_err),
    .busy      (busy)
`ifdef BARCODE_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic b);
    seg_valid = 1'b1;
    seg_in    = b;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    seg_in    = 1'b0;
  endtask

  task automatic send_code(input logic [10:0] code, input bit err, input logic [3:0] num);
    exp_t e;
    e.err = err;
    e.num = num;
    sb.push_back(e);
    for (int i = 10; i >= 0; i--) strobe(code[i]);
  endtask

  // every result pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (num_valid || code_err)) begin
      if (num_valid && code_err) check("pulse_exclusive", 1, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        check("result_kind_err", int'(code_err), int'(e.err));
        if (e.err) begin
          check("err_holds_number", int'(number), int'(last_num));
        end else begin
          check("decoded_number", int'(number), int'(e.num));
          last_num = e.num;
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{11'b10010011000, 1'b0, 4'd3,  0};
    tbl[1]  = '{11'b10110011000, 1'b0, 4'd12, 0};
    tbl[2]  = '{11'b10111001100, 1'b0, 4'd15, 3};
    tbl[3]  = '{11'b10011000101, 1'b1, 4'd0,  3};
    tbl[4]  = '{11'b10000000000, 1'b1, 4'd0,  3};
    tbl[5]  = '{11'b11001101100, 1'b0, 4'd1,  1};
    tbl[6]  = '{11'b11001100110, 1'b0, 4'd2,  1};
    tbl[7]  = '{11'b10010001100, 1'b0, 4'd4,  1};
    tbl[8]  = '{11'b10001001100, 1'b0, 4'd5,  1};
    tbl[9]  = '{11'b10011001000, 1'b0, 4'd6,  1};
    tbl[10] = '{11'b10011000100, 1'b0, 4'd7,  1};
    tbl[11] = '{11'b10001100100, 1'b0, 4'd8,  1};
    tbl[12] = '{11'b11011001101, 1'b1, 4'd0,  2};
    tbl[13] = '{11'b11001001100, 1'b0, 4'd9,  1};
    tbl[14] = '{11'b11001000100, 1'b0, 4'd10, 1};
    tbl[15] = '{11'b11000100100, 1'b0, 4'd11, 0};
    tbl[16] = '{11'b10011011100, 1'b0, 4'd13, 0};
    tbl[17] = '{11'b11111111110, 1'b1, 4'd0,  2};
    tbl[18] = '{11'b10011001110, 1'b0, 4'd14, 2};
    tbl[19] = '{11'b11011001100, 1'b0, 4'd0,  2};

    idle(2);
    check("rst_number", int'(number), 0);
    check("rst_num_valid", int'(num_valid), 0);
    check("rst_code_err", int'(code_err), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(1);

    // quiet zone, then code 0 with latency checks
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b0);
    check("quiet_busy", int'(busy), 0);
    send_code(11'b11011001100, 1'b0, 4'd0);
    check("check_busy", int'(busy), 1);
    check("latency_early", int'(num_valid), 0);
    idle(1);
    check("latency_valid", int'(num_valid), 1);
    check("latency_number", int'(number), 0);
    check("latency_no_err", int'(code_err), 0);
    idle(1);
    check("pulse_one_cycle", int'(num_valid), 0);
    check("busy_after", int'(busy), 0);

    for (int i = 0; i < 20; i++) begin
      send_code(tbl[i].code, tbl[i].err, tbl[i].num);
      idle(tbl[i].gap);
    end
    idle(3);

`ifdef BARCODE_ERR_COUNT_EN
    for (int i = 0; i < 260; i++) begin
      send_code(11'b10000000000, 1'b1, 4'd0);
      idle(1);
    end
    idle(3);
    check("err_count_sat", int'(err_count), 255);
`endif

    // inter-strobe timeout, TIMEOUT = 4
    begin
      exp_t e;
      e.err = 1'b1;
      e.num = 4'd0;
      sb.push_back(e);
    end
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    idle(3);
    check("tmo_not_yet", int'(code_err), 0);
    check("tmo_busy_hold", int'(busy), 1);
    idle(1);
    check("tmo_err", int'(code_err), 1);
    check("tmo_busy_drop", int'(busy), 0);
    idle(2);
    send_code(11'b11001001100, 1'b0, 4'd9);
    idle(3);

    // reset mid-symbol discards the partial code
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    rst_n = 1'b0;
    idle(1);
    last_num = 4'd0;
    check("mid_rst_number", int'(number), 0);
    check("mid_rst_num_valid", int'(num_valid), 0);
    check("mid_rst_code_err", int'(code_err), 0);
    check("mid_rst_busy", int'(busy), 0);
`ifdef BARCODE_ERR_COUNT_EN
    check("mid_rst_err_count", int'(err_count), 0);
`endif
    rst_n = 1'b1;
    idle(1);
    send_code(11'b11001001100, 1'b0, 4'd9);

    begin
      int t = 0;
      while (sb.size() != 0 && t < 50) begin
        idle(1);
        t++;
      end
      check("scoreboard_drained", sb.size(), 0);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
